// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: lamp encoding and monitor error-bit indices shared with the controller
package traffic_light_pkg;
  typedef logic [1:0] lamp_t;
  localparam lamp_t LAMP_RED = 2'b00;
  localparam lamp_t LAMP_GREEN = 2'b01;
  localparam lamp_t LAMP_YELLOW = 2'b10;
  localparam lamp_t LAMP_BAD = 2'b11;
  localparam int ERR_W = 6;
  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_CONFLICT = 1;
  localparam int ERR_WALK = 2;
  localparam int ERR_TRANS = 3;
  localparam int ERR_YEL_DUR = 4;
  localparam int ERR_GRN_DUR = 5;
endpackage

// File: rtl/light_phase_tracker.sv
// light_phase_tracker: follows one lamp's last legal colour and dwell, flags bad steps on the leaving edge
module light_phase_tracker
  import traffic_light_pkg::*;
#(
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 6,
  parameter int GRN_MIN = 3,
  parameter int DUR_W = 8
) (
  input logic clk,
  input logic rst_n,
  input logic [1:0] lamp,
  output logic bad_transition,
  output logic yellow_dur_err,
  output logic green_dur_err
);
  lamp_t last;
  logic [DUR_W-1:0] dwell;
  logic change;
  logic legal_step;
  always_comb begin
    change = lamp != LAMP_BAD && lamp != last;
    legal_step = (last == LAMP_RED && lamp == LAMP_GREEN) ||
                 (last == LAMP_GREEN && lamp == LAMP_YELLOW) ||
                 (last == LAMP_YELLOW && lamp == LAMP_RED);
    bad_transition = change && !legal_step;
    yellow_dur_err = change && last == LAMP_YELLOW &&
                     (dwell < DUR_W'(YEL_MIN) || dwell > DUR_W'(YEL_MAX));
    green_dur_err = change && last == LAMP_GREEN && dwell < DUR_W'(GRN_MIN);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      last <= LAMP_RED;
      dwell <= '0;
    end else if (change) begin
      last <= lamp;
      dwell <= DUR_W'(1);
    end else if (lamp != LAMP_BAD && ~&dwell)
      dwell <= dwell + DUR_W'(1);
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive safety/protocol checker on the traffic light controller outputs
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 6,
  parameter int GRN_MIN = 3,
  parameter int DUR_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  input logic [1:0] light_ns,
  input logic [1:0] light_ew,
  input logic walk_signal,
  input logic clr_status,
  output logic [5:0] err_pulse,
  output logic [5:0] err_status,
  output logic [CNT_W-1:0] viol_cnt,
  output logic any_err
);
  lamp_t s_ns;
  lamp_t s_ew;
  logic s_walk;
  logic [1:0] bt;
  logic [1:0] yd;
  logic [1:0] gd;
  logic [ERR_W-1:0] pulse;
  light_phase_tracker #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .GRN_MIN(GRN_MIN), .DUR_W(DUR_W)) u_ns (
    .clk(clk), .rst_n(rst_n), .lamp(s_ns),
    .bad_transition(bt[0]), .yellow_dur_err(yd[0]), .green_dur_err(gd[0])
  );
  light_phase_tracker #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .GRN_MIN(GRN_MIN), .DUR_W(DUR_W)) u_ew (
    .clk(clk), .rst_n(rst_n), .lamp(s_ew),
    .bad_transition(bt[1]), .yellow_dur_err(yd[1]), .green_dur_err(gd[1])
  );
  always_comb begin
    pulse = '0;
    pulse[ERR_ILLEGAL] = s_ns == LAMP_BAD || s_ew == LAMP_BAD;
    pulse[ERR_CONFLICT] = s_ns != LAMP_RED && s_ew != LAMP_RED;
    pulse[ERR_WALK] = s_walk && (s_ns != LAMP_RED || s_ew != LAMP_RED);
    pulse[ERR_TRANS] = |bt;
    pulse[ERR_YEL_DUR] = |yd;
    pulse[ERR_GRN_DUR] = |gd;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      s_ns <= LAMP_RED;
      s_ew <= LAMP_RED;
      s_walk <= 1'b0;
      err_pulse <= '0;
      err_status <= '0;
      viol_cnt <= '0;
    end else begin
      s_ns <= light_ns;
      s_ew <= light_ew;
      s_walk <= walk_signal;
      err_pulse <= pulse;
      err_status <= clr_status ? pulse : err_status | pulse;
      viol_cnt <= clr_status ? CNT_W'(|pulse) :
                  (|pulse && ~&viol_cnt) ? viol_cnt + CNT_W'(1) : viol_cnt;
    end
  assign any_err = |err_status;
endmodule
